// File: rtl/ram_sync_clr.sv
// ram_sync_clr: single-port synchronous RAM with a hardware clear sweep.
// After reset, or on a clr pulse, every word is overwritten with CLEAR_VALUE,
// one address per cycle, while busy is high. Reads and writes are accepted
// only in IDLE. Define RAM_SYNC_CLR_PARITY_EN to store an even-parity bit per
// word and add the parity_err output.
module ram_sync_clr #(
  parameter int                    ADDR_WIDTH  = 16,
  parameter int                    DATA_WIDTH  = 16,
  parameter int                    RDW_MODE    = 0,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  we,
  input  logic                  re,
  input  logic                  clr,
  output logic [DATA_WIDTH-1:0] dout,
`ifdef RAM_SYNC_CLR_PARITY_EN
  output logic                  parity_err,
`endif
  output logic                  busy
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
`ifdef RAM_SYNC_CLR_PARITY_EN
  localparam int WORD_WIDTH = DATA_WIDTH + 1;
`else
  localparam int WORD_WIDTH = DATA_WIDTH;
`endif

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_t;

  state_t                state;
  state_t                next_state;
  logic [ADDR_WIDTH-1:0] clr_ptr;
  logic [ADDR_WIDTH-1:0] next_ptr;

  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_data;
  logic [WORD_WIDTH-1:0] mem_word;
  logic                  rd_en;
  logic [WORD_WIDTH-1:0] rd_word;

  logic [WORD_WIDTH-1:0] mem [DEPTH];

  // State register, sweep pointer and registered busy flag.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (reset) begin
      state   <= CLEAR;
      clr_ptr <= '0;
      busy    <= 1'b1;
    end else begin
      state   <= next_state;
      clr_ptr <= next_ptr;
      busy    <= (next_state == CLEAR);
    end
  end

  // Next-state and next-pointer logic; a clr pulse always restarts at 0.
  always_comb begin
    // NOTE: defaults first so no path through the case leaves a latch.
    next_state = state;
    next_ptr   = clr_ptr;
    case (state)
      CLEAR: begin
        if (clr) begin
          next_ptr = '0;
        end else begin
          next_ptr = clr_ptr + 1'b1;
          if (clr_ptr == '1) next_state = IDLE;
        end
      end
      IDLE: begin
        if (clr) begin
          next_state = CLEAR;
          next_ptr   = '0;
        end
      end
      default: next_state = CLEAR;
    endcase
  end

  // Memory port steering: sweep writes in CLEAR, user access in IDLE.
  always_comb begin
    mem_we   = 1'b0;
    mem_addr = addr;
    mem_data = din;
    rd_en    = 1'b0;
    case (state)
      CLEAR: begin
        mem_we   = !clr;
        mem_addr = clr_ptr;
        mem_data = CLEAR_VALUE;
      end
      IDLE: begin
        mem_we = we && !clr;
        rd_en  = re;
      end
      default: ;
    endcase
`ifdef RAM_SYNC_CLR_PARITY_EN
    mem_word = {^mem_data, mem_data};
`else
    mem_word = mem_data;
`endif
    if (RDW_MODE == 1 && mem_we) rd_word = mem_word;
    else                         rd_word = mem[addr];
  end

  // Memory array write; reset only blocks writes.
  always_ff @(posedge clk) begin
    // NOTE: the array itself is never reset; clearing is done by the sweep,
    // which keeps it mappable onto block RAM.
    if (!reset && mem_we) mem[mem_addr] <= mem_word;
  end

  // Registered read data (and parity check), held when no read is accepted.
  always_ff @(posedge clk) begin
    if (reset) begin
      dout <= '0;
`ifdef RAM_SYNC_CLR_PARITY_EN
      parity_err <= 1'b0;
`endif
    end else if (rd_en) begin
      dout <= rd_word[DATA_WIDTH-1:0];
`ifdef RAM_SYNC_CLR_PARITY_EN
      parity_err <= ^rd_word;
`endif
    end
  end

endmodule
